// File: rtl/ptw_dcache_arb_pkg.sv
// rtl/ptw_dcache_arb_pkg.sv - shared core defines: DCache data types, PTW arbiter FSM and owner encodings
package ptw_dcache_arb_pkg;

  // DCache access size encodings; page-table walks always fetch a full doubleword.
  localparam int DATA_TYPE__LEN = 2;
  localparam logic [DATA_TYPE__LEN-1:0] DATA_TYPE_B = 2'd0;
  localparam logic [DATA_TYPE__LEN-1:0] DATA_TYPE_H = 2'd1;
  localparam logic [DATA_TYPE__LEN-1:0] DATA_TYPE_W = 2'd2;
  localparam logic [DATA_TYPE__LEN-1:0] DATA_TYPE_D = 2'd3;

  // IDLE: free to grant; BUSY: request live for its owner; DRAIN: owner gave up, waiting out the DCache.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } ptw_arb_state_e;

  // Which walker currently owns the DCache read port.
  typedef enum logic {
    OWNER_DPTW = 1'b0,
    OWNER_IPTW = 1'b1
  } ptw_owner_e;

endpackage

// File: rtl/ptw_dcache_arb.sv
// rtl/ptw_dcache_arb.sv - round-robin arbiter sharing the DCache PTW read port between data and instruction walkers
module ptw_dcache_arb
  import ptw_dcache_arb_pkg::*;
#(
  parameter int PADDR_W = 56,
  parameter int DATA_W  = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      dptw_req_valid,
  input  logic [PADDR_W-1:0]        dptw_req_paddr,
  input  logic                      iptw_req_valid,
  input  logic [PADDR_W-1:0]        iptw_req_paddr,
  output logic                      dptw_resp_done,
  output logic                      iptw_resp_done,
  output logic [DATA_W-1:0]         ptw_resp_data,
  output logic                      DCache_RdReq_PTW_Valid,
  output logic [PADDR_W-1:0]        DCache_RdReq_PTW_Paddr,
  output logic [DATA_TYPE__LEN-1:0] DCache_RdReq_PTW_DataType,
  input  logic [DATA_W-1:0]         DCache_RdResp_PTW_Data,
  input  logic                      DCache_RdResp_PTW_Done
);

  // With both walkers asking, the one holding priority wins; otherwise whoever asks.
  function automatic ptw_owner_e rr_pick(input logic d_v, input logic i_v, input ptw_owner_e prio);
    if (d_v && i_v) begin
      return prio;
    end else if (i_v) begin
      return OWNER_IPTW;
    end else begin
      return OWNER_DPTW;
    end
  endfunction

  ptw_arb_state_e     state_q, state_d;
  ptw_owner_e         owner_q, rr_q;
  logic [PADDR_W-1:0] paddr_q;

  ptw_owner_e         pick_owner;
  logic [PADDR_W-1:0] pick_paddr;
  logic               grant;
  logic               owner_valid;

  // Grants only happen from IDLE, so the DCache always sees a dead cycle after Done.
  assign grant       = (state_q == ST_IDLE) && (dptw_req_valid || iptw_req_valid);
  assign pick_owner  = rr_pick(dptw_req_valid, iptw_req_valid, rr_q);
  assign pick_paddr  = (pick_owner == OWNER_IPTW) ? iptw_req_paddr : dptw_req_paddr;
  assign owner_valid = (owner_q == OWNER_IPTW) ? iptw_req_valid : dptw_req_valid;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch the granted request and hand priority to the other walker on every grant.
  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_q <= OWNER_DPTW;
      rr_q    <= OWNER_DPTW;
      paddr_q <= '0;
    end else if (grant) begin
      owner_q <= pick_owner;
      rr_q    <= (pick_owner == OWNER_DPTW) ? OWNER_IPTW : OWNER_DPTW;
      paddr_q <= pick_paddr;
    end
  end

  // Next-state: a dropped owner valid turns the live request into a drain; Done always ends it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (dptw_req_valid || iptw_req_valid) begin
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (DCache_RdResp_PTW_Done) begin
          state_d = ST_IDLE;
        end else if (!owner_valid) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (DCache_RdResp_PTW_Done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: the request stays up until Done; completion is delivered only to a still-waiting owner.
  always_comb begin
    logic resp_ok;
    resp_ok = rst && (state_q == ST_BUSY) && DCache_RdResp_PTW_Done && owner_valid;
    DCache_RdReq_PTW_Valid    = (state_q != ST_IDLE);
    DCache_RdReq_PTW_Paddr    = paddr_q;
    DCache_RdReq_PTW_DataType = DATA_TYPE_D;
    dptw_resp_done            = resp_ok && (owner_q == OWNER_DPTW);
    iptw_resp_done            = resp_ok && (owner_q == OWNER_IPTW);
    ptw_resp_data             = DCache_RdResp_PTW_Data;
  end

endmodule

// File: doc/ptw_dcache_arb.md
PTW_DCACHE_ARB -- requirements
Module: ptw_dcache_arb

Interface
REQ-001 SHALL have parameter PADDR_W, 56, physical address width.
REQ-002 SHALL have parameter DATA_W, 64, PTE/data width.
REQ-003 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-low.
REQ-005 SHALL have ports dptw_req_valid  in  1 / dptw_req_paddr  in  PADDR_W  data-MMU walker read request; valid is level, held until done.
REQ-006 SHALL have ports iptw_req_valid  in  1 / iptw_req_paddr  in  PADDR_W  instruction-MMU walker read request; same protocol.
REQ-007 SHALL have ports dptw_resp_done  out  1 / iptw_resp_done  out  1  one-cycle completion pulse to the owning walker.
REQ-008 SHALL have port ptw_resp_data  out  DATA_W  PTE data, valid with either done pulse.
REQ-009 SHALL have ports DCache_RdReq_PTW_Valid  out  1 / DCache_RdReq_PTW_Paddr  out  PADDR_W / DCache_RdReq_PTW_DataType  out  DATA_TYPE__LEN  single DCache read port.
REQ-010 SHALL have ports DCache_RdResp_PTW_Data  in  DATA_W / DCache_RdResp_PTW_Done  in  1  DCache read response.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY, DRAIN.
REQ-012 IDLE: if any request valid, SHALL grant one, latch its paddr and owner, go BUSY; DCache valid asserts the following cycle.
REQ-013 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; pointer reset value favours dptw.
REQ-014 BUSY: DCache_RdReq_PTW_Valid SHALL be 1 and Paddr SHALL be the latched paddr, stable until Done.
REQ-015 BUSY + Done + owner valid still high: SHALL pulse owner's done in the same cycle as Done, route DCache data combinationally to ptw_resp_data, return to IDLE.
REQ-016 BUSY + owner drops valid before Done (abort/flush): SHALL go DRAIN, keep DCache valid high until Done.
REQ-017 DRAIN + Done: SHALL discard data, assert no done pulse, return to IDLE.
REQ-018 BUSY + Done in the same cycle the owner drops valid: SHALL discard data, assert no done pulse, return to IDLE.
REQ-019 Exactly one outstanding DCache request SHALL exist; a new grant SHALL be taken no earlier than the cycle after Done, so DCache valid is low for at least one cycle between requests.
REQ-020 Non-owner done SHALL never pulse; both done outputs SHALL never be high together.
REQ-021 Done while IDLE SHALL be ignored.
REQ-022 DataType SHALL be constant DATA_TYPE_D.
REQ-023 Round-robin pointer SHALL update only on grant.

Reset
REQ-024 With rst low at a clock edge: FSM SHALL be IDLE, DCache valid 0, both done 0, latched paddr 0, owner/pointer favour dptw.
REQ-025 Reset mid-BUSY/DRAIN SHALL abandon the request with no done pulse; any later DCache Done SHALL be ignored per REQ-021.
REQ-026 Outputs SHALL return to reset values in the cycle following the sampled reset edge.

Structure
REQ-027 FSM state encoding and owner enum SHALL live in the shared core defines header, next to the DATA_TYPE constants.
REQ-028 Block SHALL be a single module with no sub-modules; the round-robin pick is a small combinational function.
REQ-029 Block SHALL sit between DTLB/ITLB page-table walkers and the DCache PTW read port; the data-MMU wrapper keeps its own port names.

Verification
REQ-030 dptw only, paddr 0x0000_8000_1000, Done after 3 cycles with data 0xA5 -> DCache valid 1 cycle after request; dptw_resp_done pulse coincident with Done; ptw_resp_data=0xA5.
REQ-031 Both valid same cycle at reset -> dptw served first, iptw second; DCache valid low exactly 1 cycle between; third simultaneous pair -> dptw served.
REQ-032 iptw granted, iptw drops valid 1 cycle later, Done 4 cycles later -> FSM DRAIN, no done pulse, IDLE next cycle, pending dptw granted.
REQ-033 Owner drops valid in the same cycle as Done -> no done pulse, IDLE next cycle.
REQ-034 rst low during BUSY, stray Done after release -> valid 0 next cycle, no done pulse ever.
REQ-035 Done pulsed in IDLE with no requests -> no output change.
